// File: rtl/unreg_pkg.sv
// Shared types and bit permutations for the unreg sequencer and its next-state network.
package unreg_pkg;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_CLEAR = 2'd1,
      OP_LOAD  = 2'd2,
      OP_STEP  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Bit-reverse inside each nibble: q[4k+j] = d[4k+3-j].
   function automatic logic [15:0] nibrev16(input logic [15:0] d);
      logic [15:0] r;
      r = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         for (int unsigned j = 0; j < 4; j++) begin
            r[4*k+j] = d[4*k+3-j];
         end
      end
      return r;
   endfunction

   // Nibble shift-down; each nibble's bit 0 feeds the next nibble's bit 3.
   function automatic logic [15:0] step16(input logic [15:0] q, input logic sin);
      logic [15:0] r;
      r[2:0]   = q[3:1];
      r[3]     = sin;
      r[6:4]   = q[7:5];
      r[7]     = q[0];
      r[10:8]  = q[11:9];
      r[11]    = q[4];
      r[14:12] = q[15:13];
      r[15]    = q[8];
      return r;
   endfunction

endpackage

// File: rtl/unreg_seq_next.sv
// Combinational next-state network for the 16-bit unreg state word.
module unreg_next
   import unreg_pkg::*;
(
   input  logic [15:0] q,
   input  op_e         op,
   input  logic [15:0] cmd_data,
   input  logic        sin,
   output logic [15:0] q_nxt
);

   always_comb begin
      q_nxt = q;
      case (op)
         OP_CLEAR: q_nxt = '0;
         OP_LOAD:  q_nxt = nibrev16(cmd_data);
         OP_STEP:  q_nxt = step16(q, sin);
         default:  q_nxt = q;
      endcase
   end

endmodule

// File: rtl/unreg_seq.sv
// Registered sequencer for the unreg state word: CLEAR/LOAD/STEP/READ over valid/ready.
module unreg_seq
   import unreg_pkg::*;
#(
   parameter int unsigned CNT_W             = 5,
   parameter int unsigned CLEAR_ON_LOAD_ERR = 0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [15:0]      cmd_data,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             sin,
   output logic [15:0]      q,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);

   if (CLEAR_ON_LOAD_ERR != 0) begin : g_reserved_check
      $error("unreg_seq: CLEAR_ON_LOAD_ERR is reserved and must be 0");
   end

   state_e           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   op_e              sel_op;
   logic             q_en;
   logic             accept;
   logic [15:0]      q_nxt;

   assign cmd_ready = (state == S_IDLE) & reset_n;
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid & cmd_ready;

   unreg_next u_next (
      .q        (q),
      .op       (sel_op),
      .cmd_data (cmd_data),
      .sin      (sin),
      .q_nxt    (q_nxt)
   );

   // In RUN the network is forced to STEP; in IDLE it follows the live command.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      q_en      = 1'b0;
      sel_op    = op_e'(cmd_op);
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (op_e'(cmd_op))
                  OP_STEP: begin
                     if (cmd_count == '0) begin
                        state_nxt = S_DONE;
                     end else begin
                        cnt_nxt   = cmd_count;
                        state_nxt = S_RUN;
                     end
                  end
                  OP_CLEAR, OP_LOAD: begin
                     q_en      = 1'b1;
                     state_nxt = S_DONE;
                  end
                  default: state_nxt = S_DONE;
               endcase
            end
         end
         S_RUN: begin
            sel_op  = OP_STEP;
            q_en    = 1'b1;
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q         <= '0;
         state     <= S_IDLE;
         cnt       <= '0;
         res_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         res_valid <= (state_nxt == S_DONE);
         if (q_en) q <= q_nxt;
      end
   end

endmodule

// File: tb/tb_unreg_seq.sv
// Self-checking bench for unreg_seq: directed table, corner sequences, random commands.
module tb_unreg_seq;

   localparam int unsigned CNT_W = 5;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [15:0]      cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic             sin;
   logic [15:0]      q;
   logic             res_valid;
   logic             res_ready;
   logic             busy;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [15:0] mq;

   unreg_seq #(.CNT_W(CNT_W), .CLEAR_ON_LOAD_ERR(0)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .sin       (sin),
      .q         (q),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] data;
      int unsigned count;
      int          sin_mode;
      int unsigned hold;
      logic        rr_perm;
      logic [15:0] exp_q;
   } vec_t;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: LOAD as a per-nibble reversal lookup.
   function automatic logic [15:0] m_load(input logic [15:0] d);
      logic [3:0]  lut [16];
      logic [15:0] r;
      lut = '{4'h0, 4'h8, 4'h4, 4'hC, 4'h2, 4'hA, 4'h6, 4'hE,
              4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h7, 4'hF};
      for (int k = 0; k < 4; k++) r[4*k +: 4] = lut[d[4*k +: 4]];
      return r;
   endfunction

   // Reference: STEP as a 16-long shift chain, sin entering at bit 3.
   function automatic logic [15:0] m_step(input logic [15:0] v, input logic s);
      int          order [16];
      logic [15:0] r;
      order = '{3, 2, 1, 0, 7, 6, 5, 4, 11, 10, 9, 8, 15, 14, 13, 12};
      r = v;
      for (int i = 15; i >= 1; i--) r[order[i]] = v[order[i-1]];
      r[order[0]] = s;
      return r;
   endfunction

   task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input int unsigned count,
                         input int sin_mode, input int unsigned hold, input logic rr_perm);
      int unsigned w;
      logic        s;
      w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      check("ready_before_cmd", {15'd0, cmd_ready}, 16'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_count = CNT_W'(count);
      res_ready = rr_perm;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = 16'($urandom);
      cmd_count = CNT_W'($urandom);
      if (op == 2'd1) mq = '0;
      else if (op == 2'd2) mq = m_load(data);
      if (op == 2'd3 && count > 0) begin
         check("run_busy", {15'd0, busy}, 16'd1);
         check("run_ready", {15'd0, cmd_ready}, 16'd0);
         for (int unsigned i = 0; i < count; i++) begin
            check("run_resv_low", {15'd0, res_valid}, 16'd0);
            s   = (sin_mode == 2) ? 1'($urandom) : (sin_mode == 1);
            sin = s;
            mq  = m_step(mq, s);
            tick();
            check("run_q", q, mq);
         end
      end
      check("done_resv", {15'd0, res_valid}, 16'd1);
      check("done_q", q, mq);
      if (!rr_perm) begin
         for (int unsigned h = 0; h < hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'd2;
            cmd_data  = 16'($urandom);
            check("done_ready_low", {15'd0, cmd_ready}, 16'd0);
            tick();
            check("hold_resv", {15'd0, res_valid}, 16'd1);
            check("hold_q", q, mq);
         end
         cmd_valid = 1'b0;
         res_ready = 1'b1;
      end
      tick();
      check("idle_resv", {15'd0, res_valid}, 16'd0);
      check("idle_ready", {15'd0, cmd_ready}, 16'd1);
      check("idle_busy", {15'd0, busy}, 16'd0);
      check("idle_q", q, mq);
      if (!rr_perm) res_ready = 1'b0;
   endtask

   initial begin
      vec_t vecs [$];
      mq        = '0;
      reset_n   = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_data  = 16'hFFFF;
      cmd_count = '0;
      sin       = 1'b0;
      res_ready = 1'b0;

      // op, data, count, sin_mode, hold, rr_perm, expected q
      vecs.push_back('{2'd2, 16'h1248, 0,  0, 0,  1'b1, 16'h8421});
      vecs.push_back('{2'd2, 16'h0001, 0,  0, 0,  1'b0, 16'h0008});
      vecs.push_back('{2'd3, 16'h0000, 4,  0, 1,  1'b0, 16'h0080});
      vecs.push_back('{2'd1, 16'hDEAD, 0,  0, 0,  1'b1, 16'h0000});
      vecs.push_back('{2'd3, 16'h0000, 16, 1, 0,  1'b1, 16'hFFFF});
      vecs.push_back('{2'd3, 16'h0000, 0,  0, 2,  1'b0, 16'hFFFF});
      vecs.push_back('{2'd2, 16'h5A5A, 0,  0, 0,  1'b1, 16'hA5A5});
      vecs.push_back('{2'd1, 16'h1234, 0,  0, 10, 1'b0, 16'h0000});
      vecs.push_back('{2'd3, 16'h0000, 3,  1, 0,  1'b0, 16'h000E});
      vecs.push_back('{2'd0, 16'hFFFF, 0,  0, 1,  1'b0, 16'h000E});
      vecs.push_back('{2'd2, 16'h8000, 0,  0, 0,  1'b1, 16'h1000});
      vecs.push_back('{2'd3, 16'h0000, 1,  0, 0,  1'b1, 16'h0000});
      vecs.push_back('{2'd1, 16'h0000, 0,  0, 0,  1'b1, 16'h0000});
      vecs.push_back('{2'd3, 16'h0000, 31, 1, 0,  1'b0, 16'hFFFF});

      repeat (3) tick();
      check("rst_q", q, 16'h0000);
      check("rst_ready", {15'd0, cmd_ready}, 16'd0);
      check("rst_resv", {15'd0, res_valid}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      cmd_valid = 1'b0;
      #2 reset_n = 1'b1;
      #1 check("rel_ready", {15'd0, cmd_ready}, 16'd1);
      tick();
      check("rel_ready_clk", {15'd0, cmd_ready}, 16'd1);

      foreach (vecs[i]) begin
         do_cmd(vecs[i].op, vecs[i].data, vecs[i].count, vecs[i].sin_mode, vecs[i].hold, vecs[i].rr_perm);
         check("table_q", q, vecs[i].exp_q);
      end

      // Reset in the middle of a 20-step run, with 7 steps still pending.
      do_cmd(2'd2, 16'hFFFF, 0, 0, 0, 1'b1);
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_count = CNT_W'(20);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 13; i++) begin
         sin = 1'b0;
         mq  = m_step(mq, 1'b0);
         tick();
      end
      check("mid_q", q, 16'h7000);
      check("mid_cnt", 16'(dut.cnt), 16'd7);
      reset_n = 1'b0;
      #1;
      check("abort_q", q, 16'h0000);
      check("abort_resv", {15'd0, res_valid}, 16'd0);
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_ready", {15'd0, cmd_ready}, 16'd0);
      tick();
      tick();
      reset_n = 1'b1;
      mq = '0;
      #1;
      check("post_abort_ready", {15'd0, cmd_ready}, 16'd1);
      check("post_abort_cnt", 16'(dut.cnt), 16'd0);
      tick();
      check("post_abort_resv", {15'd0, res_valid}, 16'd0);
      check("post_abort_busy", {15'd0, busy}, 16'd0);

      for (int n = 0; n < 150; n++) begin
         do_cmd(2'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
                2, $urandom_range(0, 3), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
